// File: rtl/bram_dual_if.sv
// Request/response bundle for the two bram_dual ports: port A is read-only
// fetch, and port B is read/write with byte strobes.
interface bram_dual_if #(
  parameter int DATA_WIDTH = 32
);
  localparam int STRB = DATA_WIDTH / 8;

  logic                  a_valid;
  logic [31:0]           a_addr;
  logic [DATA_WIDTH-1:0] a_rdata;
  logic                  a_ready;

  logic                  b_valid;
  logic [31:0]           b_addr;
  logic [DATA_WIDTH-1:0] b_wdata;
  logic [STRB-1:0]       b_wstrb;
  logic [DATA_WIDTH-1:0] b_rdata;
  logic                  b_ready;

  modport master (
    output a_valid, a_addr, b_valid, b_addr, b_wdata, b_wstrb,
    input  a_rdata, a_ready, b_rdata, b_ready
  );

  modport slave (
    input  a_valid, a_addr, b_valid, b_addr, b_wdata, b_wstrb,
    output a_rdata, a_ready, b_rdata, b_ready
  );
endinterface

// File: rtl/bram_dual.sv
// Dual-port block RAM with a configurable read pipeline, selectable
// read-during-write behaviour and a sticky host-mailbox monitor.
module bram_dual #(
  parameter int          DATA_WIDTH   = 32,
  parameter int          DEPTH_LOG2   = 10,
  parameter int          READ_LATENCY = 1,
  parameter int          WRITE_MODE   = 0,
  parameter logic [31:0] HOST_ADDR    = 32'h0000_1000
) (
  input  logic                  clock,
  input  logic                  reset,
  bram_dual_if.slave            bus,
  output logic                  host_done,
  output logic                  host_pass,
  output logic [DATA_WIDTH-1:0] host_data
);
  localparam int STRB  = DATA_WIDTH / 8;
  localparam int OFF   = $clog2(STRB);
  localparam int WORDS = 2 ** DEPTH_LOG2;

  logic [DATA_WIDTH-1:0] mem [WORDS];

  logic [DEPTH_LOG2-1:0] a_idx, b_idx;
  logic                  b_wr, host_hit;
  logic [DATA_WIDTH-1:0] a_word, b_word;

  logic [READ_LATENCY-1:0] a_vld, b_vld;
  logic [DATA_WIDTH-1:0]   a_dat [READ_LATENCY];
  logic [DATA_WIDTH-1:0]   b_dat [READ_LATENCY];

  logic unused_addr_bits;
  assign unused_addr_bits = ^{bus.a_addr[31:DEPTH_LOG2+OFF], bus.a_addr[OFF-1:0],
                              bus.b_addr[OFF-1:0]};

  function automatic logic [DATA_WIDTH-1:0] merge(input logic [DATA_WIDTH-1:0] old_word,
                                                  input logic [DATA_WIDTH-1:0] new_word,
                                                  input logic [STRB-1:0]       strb);
    logic [DATA_WIDTH-1:0] res;
    res = old_word;
    for (int unsigned i = 0; i < STRB; i++) begin
      if (strb[i]) res[8*i +: 8] = new_word[8*i +: 8];
    end
    return res;
  endfunction

  assign a_idx    = bus.a_addr[DEPTH_LOG2+OFF-1:OFF];
  assign b_idx    = bus.b_addr[DEPTH_LOG2+OFF-1:OFF];
  assign b_wr     = bus.b_valid && (|bus.b_wstrb);
  assign host_hit = b_wr && !host_done && (bus.b_addr[31:OFF] == HOST_ADDR[31:OFF]);

  // The array is sampled before the edge commits the write, so the plain read
  // is naturally read-first; write-first folds the incoming lanes in here.
  always_comb begin
    a_word = mem[a_idx];
    b_word = mem[b_idx];
    if (WRITE_MODE == 1 && b_wr) begin
      b_word = merge(mem[b_idx], bus.b_wdata, bus.b_wstrb);
      if (a_idx == b_idx) a_word = merge(mem[a_idx], bus.b_wdata, bus.b_wstrb);
    end
  end

  always_ff @(posedge clock) begin
    if (bus.b_valid) begin
      for (int unsigned i = 0; i < STRB; i++) begin
        if (bus.b_wstrb[i]) mem[b_idx][8*i +: 8] <= bus.b_wdata[8*i +: 8];
      end
    end
  end

  // Data stages load only behind a valid bit, so the last stage holds the
  // most recent response between ready pulses.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      a_vld <= '0;
      b_vld <= '0;
      for (int unsigned i = 0; i < READ_LATENCY; i++) begin
        a_dat[i] <= '0;
        b_dat[i] <= '0;
      end
    end else begin
      a_vld[0] <= bus.a_valid;
      b_vld[0] <= bus.b_valid;
      if (bus.a_valid) a_dat[0] <= a_word;
      if (bus.b_valid) b_dat[0] <= b_word;
      for (int unsigned i = 1; i < READ_LATENCY; i++) begin
        a_vld[i] <= a_vld[i-1];
        b_vld[i] <= b_vld[i-1];
        if (a_vld[i-1]) a_dat[i] <= a_dat[i-1];
        if (b_vld[i-1]) b_dat[i] <= b_dat[i-1];
      end
    end
  end

  assign bus.a_ready = a_vld[READ_LATENCY-1];
  assign bus.a_rdata = a_dat[READ_LATENCY-1];
  assign bus.b_ready = b_vld[READ_LATENCY-1];
  assign bus.b_rdata = b_dat[READ_LATENCY-1];

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      host_done <= 1'b0;
      host_pass <= 1'b0;
      host_data <= '0;
    end else if (host_hit) begin
      host_done <= 1'b1;
      host_pass <= (bus.b_wdata == {{(DATA_WIDTH-1){1'b0}}, 1'b1});
      host_data <= bus.b_wdata;
    end
  end
endmodule

// File: tb/tb_bram_dual.sv
// Scoreboard bench for bram_dual: three instances cover read-first/latency 1,
// write-first/latency 3 and a 16-word/latency 2 build with reset and wrap.
module tb_bram_dual;
  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic [2:0]        rstn;
  logic [2:0]        a_valid, b_valid, a_ready, b_ready;
  logic [2:0][31:0]  a_addr, b_addr, b_wdata, a_rdata, b_rdata, host_data;
  logic [2:0][3:0]   b_wstrb;
  logic [2:0]        host_done, host_pass;

  int unsigned cyc = 0;
  int checks = 0;
  int errors = 0;

  always @(posedge clock) cyc <= cyc + 1;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam int RL = (g == 0) ? 1 : ((g == 1) ? 3 : 2);
    localparam int WM = (g == 1) ? 1 : 0;
    localparam int DL = (g == 2) ? 4 : 10;
    bram_dual_if #(.DATA_WIDTH(32)) bus ();
    assign bus.a_valid = a_valid[g];
    assign bus.a_addr  = a_addr[g];
    assign bus.b_valid = b_valid[g];
    assign bus.b_addr  = b_addr[g];
    assign bus.b_wdata = b_wdata[g];
    assign bus.b_wstrb = b_wstrb[g];
    assign a_rdata[g]  = bus.a_rdata;
    assign a_ready[g]  = bus.a_ready;
    assign b_rdata[g]  = bus.b_rdata;
    assign b_ready[g]  = bus.b_ready;
    bram_dual #(
      .DATA_WIDTH(32), .DEPTH_LOG2(DL), .READ_LATENCY(RL),
      .WRITE_MODE(WM), .HOST_ADDR(32'h0000_1000)
    ) u_dut (
      .clock(clock), .reset(rstn[g]), .bus(bus),
      .host_done(host_done[g]), .host_pass(host_pass[g]), .host_data(host_data[g])
    );
  end

  typedef struct {
    int unsigned port;
    int unsigned due;
    logic [31:0] data;
    bit          chk;
  } sb_t;
  sb_t sb[$];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic int unsigned rl(input int unsigned d);
    return (d == 0) ? 1 : ((d == 1) ? 3 : 2);
  endfunction

  task automatic a_req(input int unsigned d, input logic [31:0] addr,
                       input logic [31:0] exp, input bit chk);
    a_valid[d] = 1'b1;
    a_addr[d]  = addr;
    sb.push_back('{port: 2*d, due: cyc + rl(d), data: exp, chk: chk});
  endtask

  task automatic b_req(input int unsigned d, input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [3:0] strb, input logic [31:0] exp, input bit chk);
    b_valid[d] = 1'b1;
    b_addr[d]  = addr;
    b_wdata[d] = wdata;
    b_wstrb[d] = strb;
    sb.push_back('{port: 2*d+1, due: cyc + rl(d), data: exp, chk: chk});
  endtask

  task automatic tick();
    @(posedge clock);
    @(negedge clock);
    a_valid = '0;
    b_valid = '0;
    b_wstrb = '0;
  endtask

  // Each port's responses must arrive in order, on the due cycle, with the queued data.
  always @(negedge clock) begin
    for (int p = 0; p < 6; p++) begin
      int idx;
      logic rdy;
      logic [31:0] rd;
      idx = -1;
      rdy = (p % 2 == 1) ? b_ready[p/2] : a_ready[p/2];
      rd  = (p % 2 == 1) ? b_rdata[p/2] : a_rdata[p/2];
      for (int k = 0; k < sb.size(); k++) begin
        if (sb[k].port == p) begin
          idx = k;
          break;
        end
      end
      if (rdy) begin
        if (idx < 0) check($sformatf("p%0d_spurious_ready", p), 64'(rdy), 64'd0);
        else begin
          check($sformatf("p%0d_latency", p), 64'(cyc), 64'(sb[idx].due));
          if (sb[idx].chk) check($sformatf("p%0d_data", p), 64'(rd), 64'(sb[idx].data));
          sb.delete(idx);
        end
      end else if (idx >= 0 && sb[idx].due <= cyc) begin
        check($sformatf("p%0d_missing_ready", p), 64'(rdy), 64'd1);
        sb.delete(idx);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rstn = '0;
    a_valid = '0; b_valid = '0; b_wstrb = '0;
    a_addr = '0; b_addr = '0; b_wdata = '0;
    repeat (3) @(negedge clock);
    check("rst_a_ready", 64'(a_ready), 64'd0);
    check("rst_b_ready", 64'(b_ready), 64'd0);
    check("rst_a_rdata", 64'(a_rdata[0]), 64'd0);
    check("rst_b_rdata", 64'(b_rdata[1]), 64'd0);
    check("rst_host", {host_done, host_pass, host_data[0][15:0]}, 64'd0);
    rstn = '1;

    // Byte-strobe merge, latency 1
    b_req(0, 32'h40, 32'hAABB_CCDD, 4'hF, 32'h0, 1'b0); tick();
    b_req(0, 32'h40, 32'h0000_0011, 4'h1, 32'h0, 1'b0); tick();
    a_req(0, 32'h40, 32'hAABB_CC11, 1'b1); tick();
    tick();

    // Read-first collision
    b_req(0, 32'h80, 32'h0, 4'hF, 32'h0, 1'b0); tick();
    a_req(0, 32'h80, 32'h0, 1'b1);
    b_req(0, 32'h80, 32'h5A5A_5A5A, 4'hF, 32'h0, 1'b1); tick();
    a_req(0, 32'h80, 32'h5A5A_5A5A, 1'b1); tick();
    tick();

    // Host mailbox pass, then frozen
    check("host0_idle", 64'(host_done[0]), 64'd0);
    b_req(0, 32'h1000, 32'h1, 4'hF, 32'h0, 1'b0); tick();
    check("host0_done", 64'(host_done[0]), 64'd1);
    check("host0_pass", 64'(host_pass[0]), 64'd1);
    check("host0_data", 64'(host_data[0]), 64'd1);
    b_req(0, 32'h1000, 32'h3, 4'hF, 32'h0, 1'b0); tick();
    tick();
    check("host0_frozen", {host_done[0], host_pass[0], host_data[0]}, {2'b11, 32'h1});
    a_req(0, 32'h1000, 32'h3, 1'b1); tick();
    tick();

    // Latency 3 throughput with write-first
    for (int i = 0; i < 8; i++) begin
      b_req(1, 32'(i * 4), 32'h0101_0000 + 32'(i) * 32'h11, 4'hF,
            32'h0101_0000 + 32'(i) * 32'h11, 1'b1);
      tick();
    end
    for (int i = 0; i < 8; i++) begin
      a_req(1, 32'(i * 4), 32'h0101_0000 + 32'(i) * 32'h11, 1'b1);
      tick();
    end
    b_req(1, 32'h8, 32'h0, 4'h0, 32'h0101_0022, 1'b1); tick();
    repeat (4) tick();

    b_req(1, 32'h200, 32'h0, 4'hF, 32'h0, 1'b1); tick();
    a_req(1, 32'h200, 32'h5A5A_5A5A, 1'b1);
    b_req(1, 32'h200, 32'h5A5A_5A5A, 4'hF, 32'h5A5A_5A5A, 1'b1); tick();
    a_req(1, 32'h200, 32'h5A5A_5A5A, 1'b1); tick();
    repeat (4) tick();

    // Strobe-less access to the mailbox is a read; first real write of 3 fails
    b_req(2, 32'h1000, 32'h1, 4'h0, 32'h0, 1'b0); tick();
    tick();
    check("host2_read_no_trigger", 64'(host_done[2]), 64'd0);
    b_req(2, 32'h1000, 32'h3, 4'hF, 32'h0, 1'b0); tick();
    check("host2_done", 64'(host_done[2]), 64'd1);
    check("host2_pass", 64'(host_pass[2]), 64'd0);
    check("host2_data", 64'(host_data[2]), 64'd3);
    repeat (2) tick();

    // Reset with two reads in flight (latency 2)
    a_req(2, 32'h4, 32'h0, 1'b0); tick();
    a_req(2, 32'h8, 32'h0, 1'b0);
    @(posedge clock);
    #1 rstn[2] = 1'b0;
    for (int k = sb.size() - 1; k >= 0; k--) begin
      if (sb[k].port >= 4) sb.delete(k);
    end
    #1;
    check("rst2_ready", {62'd0, a_ready[2], b_ready[2]}, 64'd0);
    check("rst2_rdata", {a_rdata[2], b_rdata[2]}, 64'd0);
    check("rst2_host", {host_done[2], host_pass[2], host_data[2]}, 64'd0);
    @(negedge clock);
    a_valid = '0; b_valid = '0; b_wstrb = '0;
    repeat (2) @(negedge clock);
    rstn[2] = 1'b1;

    // Wrap: 16 words of 4 bytes, so byte 0x40 aliases word 0
    b_req(2, 32'h0, 32'hCAFE_F00D, 4'hF, 32'h0, 1'b0); tick();
    a_req(2, 32'h40, 32'hCAFE_F00D, 1'b1); tick();
    repeat (5) tick();

    check("scoreboard_drained", 64'(sb.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
